// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states,
// header field layout and payload/address limits.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_PAR  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  // Header byte layout: destination in the low bits, length above it.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam int         MAX_PAYLOAD  = 63;
  localparam int         BUF_DEPTH    = MAX_PAYLOAD + 1;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// 64x8 payload store with its own write and read pointers. Both pointers
// are cleared together when a new command is accepted.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [7:0] i_wdata,
  input  logic       i_rd_inc,
  output logic [5:0] o_wptr,
  output logic [5:0] o_rptr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [BUF_DEPTH];
  logic [5:0] r_wptr;
  logic [5:0] r_rptr;

  // Payload write; contents need no reset since every byte is written before it is read.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer bookkeeping: clear on a new command, otherwise advance on write/read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_we)     r_wptr <= r_wptr + 6'd1;
      if (i_rd_inc) r_rptr <= r_rptr + 6'd1;
    end
  end

  assign o_wptr  = r_wptr;
  assign o_rptr  = r_rptr;
  assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a whole payload, then emits
// header, payload and parity back-to-back under busy back-pressure,
// followed by an inter-frame gap.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IFG   = 2,
  parameter int LEN_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       dest_addr,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             cmd_ready,
  output logic             cmd_err,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  output logic [7:0]       data_out,
  output logic             pkt_valid,
  input  logic             busy,
  input  logic             error,
  output logic             done,
  output logic [7:0]       err_cnt
);

  localparam logic [7:0] GAP_LAST = (IFG > 0) ? 8'(IFG - 1) : 8'd0;

  state_t           r_state;
  logic [1:0]       r_addr;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_parity;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_cmd_ready;
  logic             r_cmd_err;
  logic             r_done;
  logic [7:0]       r_gap;
  logic             r_err_prev;
  logic [7:0]       r_err_cnt;

  logic             w_cmd_bad;
  logic             w_buf_clr;
  logic             w_buf_we;
  logic             w_rd_inc;
  logic [5:0]       w_wptr;
  logic [5:0]       w_rptr;
  logic [7:0]       w_rdata;
  logic [7:0]       w_header;

  assign w_cmd_bad = (dest_addr == ADDR_INVALID) || (pkt_len == '0);
  assign w_buf_clr = (r_state == ST_IDLE) && start && !w_cmd_bad;
  assign w_buf_we  = (r_state == ST_LOAD) && pl_valid;
  // The read pointer moves whenever a payload byte is moved onto data_out.
  assign w_rd_inc  = !busy && ((r_state == ST_HDR) ||
                               ((r_state == ST_PAY) && (w_rptr != r_len)));
  assign w_header  = make_header(r_len, r_addr);
  assign pl_ready  = (r_state == ST_LOAD);

  router_pkt_buf u_buf (
    .clock    (clock),
    .resetn   (resetn),
    .i_clr    (w_buf_clr),
    .i_we     (w_buf_we),
    .i_wdata  (pl_data),
    .i_rd_inc (w_rd_inc),
    .o_wptr   (w_wptr),
    .o_rptr   (w_rptr),
    .o_rdata  (w_rdata)
  );

  // Main transmit FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_parity    <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_cmd_err   <= 1'b0;
      r_done      <= 1'b0;
      r_gap       <= '0;
    end else begin
      r_cmd_err <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cmd_bad) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_addr      <= dest_addr;
              r_len       <= pkt_len;
              r_parity    <= make_header(pkt_len, dest_addr);
              r_cmd_ready <= 1'b0;
              r_state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (pl_valid) begin
            r_parity <= r_parity ^ pl_data;
            if (w_wptr == r_len - 6'd1) begin
              r_data  <= w_header;
              r_valid <= 1'b1;
              r_state <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (!busy) begin
            r_data  <= w_rdata;
            r_state <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (!busy) begin
            if (w_rptr == r_len) begin
              r_data  <= r_parity;
              r_valid <= 1'b0;
              r_state <= ST_PAR;
            end else begin
              r_data <= w_rdata;
            end
          end
        end
        ST_PAR: begin
          if (!busy) begin
            r_data <= '0;
            r_gap  <= '0;
            if (IFG == 0) begin
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of router error rising edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_err_prev <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_err_prev <= error;
      if (error && !r_err_prev && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign cmd_err   = r_cmd_err;
  assign data_out  = r_data;
  assign pkt_valid = r_valid;
  assign done      = r_done;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source for the 1x3 router. Drives the router's input side: data_in, pkt_valid, busy and error.
- Accepts a transmit command (destination, length) plus a payload byte stream, and buffers the whole payload internally.
- Emits header, payload and parity with no bubbles, honouring the router's busy back-pressure.
- Used as the stimulus and traffic engine in front of router_top.

Parameters:
- IFG, 2, idle cycles (pkt_valid=0, data=0) inserted after each parity byte before the next command is accepted.
- LEN_W, 6, payload length width. Fixed by the header format; not to be changed.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled only when cmd_ready=1.
- dest_addr  in  2  destination port, 0..2.
- pkt_len  in  6  payload byte count, 1..63.
- cmd_ready  out  1  high in IDLE only.
- cmd_err  out  1  one-cycle pulse when a start is rejected.
- pl_data  in  8  payload byte.
- pl_valid  in  1  payload byte valid.
- pl_ready  out  1  payload byte accepted when pl_valid & pl_ready.
- data_out  out  8  to router data_in.
- pkt_valid  out  1  to router pkt_valid.
- busy  in  1  from router busy.
- error  in  1  from router error.
- done  out  1  one-cycle pulse when the IFG ends.
- err_cnt  out  8  saturating count of router error rising edges.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1 once in IDLE. Buffer contents are don't-care. Reset is effective mid-packet: the next cycle shows pkt_valid=0, data_out=0 and state IDLE.
- All outputs are registered; the only combinational path is pl_ready, which is decoded from state.
- Header byte = {pkt_len, dest_addr}.
- Parity byte = XOR of the header and every payload byte, accumulated during LOAD.
- Command check: start with dest_addr==3 or pkt_len==0 gives a cmd_err pulse on the next cycle; state stays IDLE.
- State IDLE: cmd_ready=1. A valid start latches addr and len, seeds parity with the header, clears the write pointer, and moves to LOAD.
- State LOAD: pl_ready=1.
  - Each accepted byte is written to buf[wptr], XORed into parity, and wptr increments.
  - When the byte at wptr==len-1 is accepted, go to HDR. That edge also loads data_out=header and pkt_valid=1.
- Transfer rule for HDR/PAY/PAR: the byte on data_out is consumed at a rising edge where busy==0. While busy==1, data_out and pkt_valid hold unchanged.
- State HDR: on consume, data_out=buf[0], rptr=1, go to PAY.
- State PAY: on consume:
  - If rptr==len, load data_out=parity and pkt_valid=0, go to PAR.
  - Otherwise load data_out=buf[rptr] and increment rptr.
  - pkt_valid stays high for exactly header+len consumed bytes. It never drops mid-payload.
- State PAR: on consume, data_out=0, start the gap counter, go to GAP.
- State GAP: count IFG cycles (busy ignored), then pulse done and go to IDLE. With IFG=0, go straight to IDLE with the done pulse.
- start outside IDLE is ignored: no cmd_err, no effect.
- Buffer: 64x8 register array. Write and read never overlap; LOAD completes before HDR.
- err_cnt increments by one on each 0->1 transition of error (registered previous value). Saturates at 255. Cleared only by reset.

Decomposition:
- Shared package router_pkg holds:
  - state encoding (IDLE, LOAD, HDR, PAY, PAR, GAP);
  - header field positions (addr [1:0], len [7:2]);
  - MAX_PAYLOAD=63 and the invalid-address constant 2'b11.
- One natural sub-module: router_pkt_buf, the 64x8 payload store with wptr/rptr and a write-enable port.

Test Plan:
- Reset, then start addr=1 len=3, payload 0x11,0x22,0x33, busy=0. Required: data_out 0x0D, 0x11, 0x22, 0x33 with pkt_valid=1, then parity 0x0D with pkt_valid=0, then 2 idle cycles, then done pulse and cmd_ready=1.
- Same packet with busy=1 for 3 cycles during HDR and 2 cycles during PAR. Required: data_out and pkt_valid held stable throughout; byte sequence identical to the first test.
- start with addr=3 len=5, and separately addr=0 len=0. Required: cmd_err pulse one cycle later, pl_ready stays 0, state stays IDLE.
- addr=2 len=63, payload 0..62 with pl_valid toggling randomly. Required: header 0xFE, 63 payload bytes in order, parity equal to XOR of all, pkt_valid high for exactly 64 consumed bytes.
- resetn low during the 10th payload byte. Required: pkt_valid=0 and data_out=0 immediately; cmd_ready=1 after release; a new packet transmits correctly.
- error pulses 3 times, then held high for 300 cycles with repeated edges. Required: err_cnt=3 after the pulses, saturates at 255, and a start during GAP is ignored.
